pipe_hazard_ctrl: RTL

//  Parametrised hazard controller for the in-order pipeline: a scoreboard of in-flight destinations

---
 rtl/pipe_hazard_ctrl.sv | 96 +++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: in-flight destination scoreboard driving forward selects, load-use stalls and branch flushes.
// Optional HAZARD_PERF_EN adds saturating stall_cycles / flush_count counters.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W = 4,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int BR_ENTRY   = 2,
  localparam int FWD_W     = $clog2(DEPTH)
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rn1,
  input  logic                  id_rn1_used,
  input  logic [REG_ADDR_W-1:0] id_rn2,
  input  logic                  id_rn2_used,
  input  logic [REG_ADDR_W-1:0] id_wn,
  input  logic                  id_enrw,
  input  logic                  id_is_load,
  input  logic                  branch_taken,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  idex_bubble,
  output logic                  flush,
  output logic [FWD_W-1:0]      fwd_a,
  output logic [FWD_W-1:0]      fwd_b
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_count
`endif
);
  logic [DEPTH:1] sbValid, sbEnrw, sbLoad;
  logic [REG_ADDR_W-1:0] sbWn [DEPTH:1];
  logic [FWD_W-1:0] selA, selB;
  logic hazard, stall, insert;
  // Walk oldest to youngest so the youngest match overwrites the select.
  always_comb begin
    logic hA, hB;
    selA = '0;
    selB = '0;
    hazard = 1'b0;
    hA = 1'b0;
    hB = 1'b0;
    for (int i = DEPTH; i >= 1; i--) begin
      hA = id_rn1_used && sbValid[i] && sbEnrw[i] && sbWn[i] == id_rn1;
      hB = id_rn2_used && sbValid[i] && sbEnrw[i] && sbWn[i] == id_rn2;
      if (i < DEPTH && hA) selA = FWD_W'(i);
      if (i < DEPTH && hB) selB = FWD_W'(i);
      if ((hA || hB) && sbLoad[i] && i < LOAD_STAGE) hazard = 1'b1;
    end
  end
  always_comb begin
    flush = ~Reset & branch_taken;
    stall = ~Reset & ~branch_taken & hazard;
    pc_write = ~stall;
    ifid_write = ~stall;
    idex_bubble = stall | flush;
    insert = id_valid & ~stall & ~flush;
  end
  // Entries younger than the branch are squashed as they shift past it.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sbValid <= '0;
      sbEnrw <= '0;
      sbLoad <= '0;
      for (int i = 1; i <= DEPTH; i++) sbWn[i] <= '0;
      fwd_a <= '0;
      fwd_b <= '0;
    end else begin
      sbValid[1] <= insert;
      sbEnrw[1] <= insert & id_enrw;
      sbLoad[1] <= insert & id_is_load;
      sbWn[1] <= id_wn;
      for (int i = 2; i <= DEPTH; i++) begin
        sbValid[i] <= sbValid[i-1] & ~(flush && (i - 1) < BR_ENTRY);
        sbEnrw[i] <= sbEnrw[i-1];
        sbLoad[i] <= sbLoad[i-1];
        sbWn[i] <= sbWn[i-1];
      end
      fwd_a <= insert ? selA : '0;
      fwd_b <= insert ? selB : '0;
    end
  end
`ifdef HAZARD_PERF_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_cycles <= '0;
      flush_count <= '0;
    end else begin
      if (stall && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
      if (flush && flush_count != '1) flush_count <= flush_count + 32'd1;
    end
  end
`endif
endmodule
